// File: rtl/ycr_arb_pkg.sv
// rtl/ycr_arb_pkg.sv - shared types and constants for the core-interface arbiter and its response path
package ycr_arb_pkg;

  localparam int         N_REQ  = 8;
  localparam int         ID_W   = 3;
  localparam logic [3:0] GRANTX = 4'hF;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    FSM_GRANT    = 2'd0,
    WAIT_REQ_ACK = 2'd1,
    WAIT_LACK    = 2'd2
  } arb_fsm_t;

endpackage

// File: rtl/ycr_id_fifo.sv
// rtl/ycr_id_fifo.sv - in-order queue of granted requester IDs awaiting their response
module ycr_id_fifo
  import ycr_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  req_id_t       din,
  input  logic          pop,
  output req_id_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_id_t       mem_q [DEPTH];
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q;
  logic          full_q;
  logic          push_ok, pop_ok;

  // A push into a full queue is allowed only when a pop frees the head slot this cycle
  assign pop_ok  = pop & (cnt_q != '0);
  assign push_ok = push & (~full_q | pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + CW'(1);
    if (pop_ok)  rd_d = rd_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= wr_d - rd_d;
      full_q <= ((wr_d - rd_d) == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign full  = full_q;
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/ycr_arb_resp.sv
// rtl/ycr_arb_resp.sv - routes downstream responses back to the requester that owns each command
module ycr_arb_resp #(
  parameter int N_REQ = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [3:0]               gnt,
  input  logic                     req_ack,
  input  logic                     resp_valid,
  input  logic [DW-1:0]            resp_rdata,
  input  logic                     resp_err,
  output logic                     cmd_full,
  output logic [N_REQ-1:0]         core_ack,
  output logic [DW-1:0]            core_rdata,
  output logic                     core_err,
  output logic                     lack,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_ovf,
  output logic                     err_orphan,
  output logic                     err_nogrant
);
  import ycr_arb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_req, push, pop;
  logic          q_full, q_empty;
  req_id_t       head_id;
  logic [CW-1:0] q_count;

  logic          valid_q;
  req_id_t       id_q;
  logic [DW-1:0] rdata_q;
  logic          rerr_q;
  logic          ovf_q, orphan_q, nogrant_q;

  // gnt[3] covers GRANTX as well as any other out-of-range grant code
  assign push_req = req_ack & ~gnt[3];
  assign pop      = resp_valid & ~q_empty;
  assign push     = push_req & (~q_full | pop);

  ycr_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (gnt[ID_W-1:0]),
    .pop   (pop),
    .dout  (head_id),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q   <= 1'b0;
      id_q      <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      orphan_q  <= 1'b0;
      nogrant_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) begin
        id_q    <= head_id;
        rdata_q <= resp_rdata;
        rerr_q  <= resp_err;
      end
      ovf_q     <= ovf_q | (push_req & q_full & ~pop);
      orphan_q  <= orphan_q | (resp_valid & q_empty);
      nogrant_q <= nogrant_q | (req_ack & gnt[3]);
    end
  end

  always_comb begin
    core_ack = '0;
    if (valid_q) core_ack[id_q] = 1'b1;
  end

  assign core_rdata  = rdata_q;
  assign core_err    = rerr_q;
  assign lack        = valid_q;
  assign cmd_full    = q_full;
  assign outstanding = q_count;
  assign err_ovf     = ovf_q;
  assign err_orphan  = orphan_q;
  assign err_nogrant = nogrant_q;

endmodule
